tx_intf_s_axis_to_pl: RTL and testbench
=======================================

Name: tx_intf_s_axis_to_pl

Overview:
- Transmit-side counterpart of the rx DMA path. Accepts packets streamed from the PS AXI DMA (MM2S) on a 64-bit AXI-Stream slave.
- Strips and decodes the two DMA header words: TSF start time, then rate/len/flags.
- Writes payload words into the tx BRAM and hands a ready packet to the tx PHY controller. Raises an interrupt to the PS once the PHY reports the packet sent.
- Detects tlast timeout and length mismatch, and recovers from both.

Parameters:
- C_S00_AXIS_TDATA_WIDTH, 64, stream data width (header layout fixed for 64).
- MAX_BIT_NUM_DMA_SYMBOL, 14, width of BRAM word address and word counters.
- TSF_TIMER_WIDTH, 64, width of the TSF start time field.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- s_axis_tdata  in  64  stream data from the DMA.
- s_axis_tvalid  in  1  stream data valid.
- s_axis_tlast  in  1  last word of the DMA transfer.
- s_axis_tready  out  1  stream ready.
- enable  in  1  when 0, the block stays in IDLE and does not accept a new packet.
- timeout_enable  in  1  enables the tlast timeout.
- timeout_top  in  13  timeout limit in microseconds.
- tsf_pulse_1M  in  1  one-cycle 1 MHz tick.
- tx_done  in  1  one-cycle pulse from the PHY: packet transmitted.
- payload_wr_en  out  1  BRAM write strobe.
- payload_wr_addr  out  MAX_BIT_NUM_DMA_SYMBOL  BRAM word address.
- payload_wr_data  out  64  BRAM write data.
- tsf_start  out  64  latched header word0; 0 means transmit immediately.
- pkt_len  out  16  latched payload length in bytes.
- pkt_rate  out  4  latched rate/MCS.
- ht_flag  out  1  latched HT flag.
- ht_sgi  out  1  latched short-GI flag.
- queue_idx  out  2  latched queue index.
- num_dma_word  out  MAX_BIT_NUM_DMA_SYMBOL  expected payload word count.
- tx_pkt_ready  out  1  level: packet complete in BRAM, waiting for the PHY.
- tx_pkt_intr  out  1  one-cycle interrupt pulse to the PS.
- len_err  out  1  one-cycle pulse on length or format error.
- timeout_recover  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset: all outputs are 0, state is IDLE, counters are 0. Reset asserted mid-operation aborts immediately. BRAM contents are not cleared.
- Header word1 layout:
  - [15:0] pkt_len
  - [19:16] rate
  - [20] ht_flag
  - [21] ht_sgi
  - [23:22] queue_idx
  - [63:24] reserved, ignored.
- A word is accepted on a cycle where tvalid and tready are both 1.
- tready is 1 only in HDR0, HDR1, PAYLOAD and DRAIN; it is registered and must not depend combinationally on tvalid.
- States and transitions:
  - IDLE: tready=0, timer cleared. Go to HDR0 when enable=1.
  - HDR0: on accept, tsf_start<=tdata. tlast=1 -> len_err pulse, go to IDLE. Otherwise go to HDR1.
  - HDR1: on accept, latch the header fields and set num_dma_word<=len[15:3]+(len[2:0]!=0); word_cnt<=0.
    - len==0: go to DRAIN if tlast=0, to IDLE if tlast=1; len_err pulses in both cases.
    - tlast=1 with len!=0: len_err pulse, go to IDLE.
    - Otherwise go to PAYLOAD.
  - PAYLOAD: on accept, payload_wr_en=1 the next cycle with addr=word_cnt and data=tdata (1-cycle registered latency); word_cnt++.
    - tlast=1 and word_cnt+1==num_dma_word: go to WAIT_TX_DONE.
    - tlast=1 early: len_err pulse, go to IDLE.
    - word_cnt+1==num_dma_word with tlast=0: len_err pulse, go to DRAIN.
  - DRAIN: accept and discard words (no BRAM write) until tlast, then go to IDLE.
  - WAIT_TX_DONE: tready=0, tx_pkt_ready=1. On tx_done: tx_pkt_ready<=0, tx_pkt_intr pulses on the next cycle, go to IDLE. A tx_done in any other state is ignored.
- Timeout:
  - In HDR1, PAYLOAD and DRAIN, the timer increments on each tsf_pulse_1M and is cleared on every accepted word.
  - If timer>timeout_top and timeout_enable=1: timeout_recover pulse, tready<=0, go to IDLE. Timeout takes priority over a word accepted in the same cycle; that word is dropped.
  - HDR0 and WAIT_TX_DONE never time out.
- Header output fields hold their values until the next HDR1 accept.

Test Plan:
- pkt_len=20, rate=4, ht_sgi=1, 3 payload words, tlast on the 3rd -> wr_addr 0,1,2 written; num_dma_word=3; tx_pkt_ready=1 until tx_done; tx_pkt_intr pulses one cycle after tx_done.
- pkt_len=16, tlast on payload word 1 -> len_err pulse, only addr 0 written, tx_pkt_ready stays 0, next packet accepted normally.
- pkt_len=8, 3 payload words with tlast on the 3rd -> addr 0 written, len_err pulse, words 2-3 drained, state returns to IDLE.
- timeout_top=5, timeout_enable=1, tvalid stalls in PAYLOAD for 7 us -> timeout_recover pulse about 6 us after the last accept, tready=0, block in IDLE; repeat with timeout_enable=0 -> block waits indefinitely.
- Random tvalid gaps with pkt_len=1500 -> 188 words written in order, data matches, tx_pkt_ready asserted once.
- Assert rst during PAYLOAD -> all outputs 0 within the reset window; a fresh packet afterwards completes correctly.

Source files
------------

// File: rtl/tx_intf_s_axis_to_pl.sv
// Strips the two-word DMA header from the MM2S stream, writes the payload into tx BRAM and
// hands the packet to the PHY; aborts on tlast timeout or length mismatch.
module tx_intf_s_axis_to_pl #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 64,
  parameter int MAX_BIT_NUM_DMA_SYMBOL = 14,
  parameter int TSF_TIMER_WIDTH        = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  input  logic                              enable,
  input  logic                              timeout_enable,
  input  logic [12:0]                       timeout_top,
  input  logic                              tsf_pulse_1M,
  input  logic                              tx_done,
  output logic                              payload_wr_en,
  output logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] payload_wr_addr,
  output logic [C_S00_AXIS_TDATA_WIDTH-1:0] payload_wr_data,
  output logic [TSF_TIMER_WIDTH-1:0]        tsf_start,
  output logic [15:0]                       pkt_len,
  output logic [3:0]                        pkt_rate,
  output logic                              ht_flag,
  output logic                              ht_sgi,
  output logic [1:0]                        queue_idx,
  output logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] num_dma_word,
  output logic                              tx_pkt_ready,
  output logic                              tx_pkt_intr,
  output logic                              len_err,
  output logic                              timeout_recover
);
  localparam int DW = C_S00_AXIS_TDATA_WIDTH;
  localparam int AW = MAX_BIT_NUM_DMA_SYMBOL;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_PAYLOAD, S_DRAIN, S_WAIT_TX_DONE
  } state_t;

  state_t                     state_q, state_d;
  logic                       tready_q, tready_d;
  logic [13:0]                timer_q, timer_d;
  logic [AW-1:0]              word_cnt_q, word_cnt_d;
  logic [AW-1:0]              num_dma_word_q, num_dma_word_d;
  logic                       wr_en_q, wr_en_d;
  logic [AW-1:0]              wr_addr_q, wr_addr_d;
  logic [DW-1:0]              wr_data_q, wr_data_d;
  logic [TSF_TIMER_WIDTH-1:0] tsf_start_q, tsf_start_d;
  logic [15:0]                pkt_len_q, pkt_len_d;
  logic [3:0]                 pkt_rate_q, pkt_rate_d;
  logic                       ht_flag_q, ht_flag_d;
  logic                       ht_sgi_q, ht_sgi_d;
  logic [1:0]                 queue_idx_q, queue_idx_d;
  logic                       tx_pkt_ready_q, tx_pkt_ready_d;
  logic                       tx_pkt_intr_q, tx_pkt_intr_d;
  logic                       len_err_q, len_err_d;
  logic                       timeout_recover_q, timeout_recover_d;

  logic          accept;
  logic          in_timed_state;
  logic          timed_out;
  logic [AW-1:0] word_cnt_inc;

  always_comb begin
    state_d           = state_q;
    timer_d           = timer_q;
    word_cnt_d        = word_cnt_q;
    num_dma_word_d    = num_dma_word_q;
    wr_en_d           = 1'b0;
    wr_addr_d         = wr_addr_q;
    wr_data_d         = wr_data_q;
    tsf_start_d       = tsf_start_q;
    pkt_len_d         = pkt_len_q;
    pkt_rate_d        = pkt_rate_q;
    ht_flag_d         = ht_flag_q;
    ht_sgi_d          = ht_sgi_q;
    queue_idx_d       = queue_idx_q;
    tx_pkt_intr_d     = 1'b0;
    len_err_d         = 1'b0;
    timeout_recover_d = 1'b0;

    accept         = s_axis_tvalid && tready_q;
    word_cnt_inc   = word_cnt_q + AW'(1);
    in_timed_state = (state_q == S_HDR1) || (state_q == S_PAYLOAD) || (state_q == S_DRAIN);
    timed_out      = in_timed_state && timeout_enable && (timer_q > {1'b0, timeout_top});

    // Timer saturates so a long stall with the timeout disabled never wraps back under the limit.
    if (!in_timed_state || accept)
      timer_d = '0;
    else if (tsf_pulse_1M && (timer_q != '1))
      timer_d = timer_q + 14'd1;

    if (timed_out) begin
      timeout_recover_d = 1'b1;
      timer_d           = '0;
      state_d           = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (enable) state_d = S_HDR0;
        end
        S_HDR0: begin
          if (accept) begin
            tsf_start_d = s_axis_tdata[TSF_TIMER_WIDTH-1:0];
            if (s_axis_tlast) begin
              len_err_d = 1'b1;
              state_d   = S_IDLE;
            end else begin
              state_d = S_HDR1;
            end
          end
        end
        S_HDR1: begin
          if (accept) begin
            pkt_len_d      = s_axis_tdata[15:0];
            pkt_rate_d     = s_axis_tdata[19:16];
            ht_flag_d      = s_axis_tdata[20];
            ht_sgi_d       = s_axis_tdata[21];
            queue_idx_d    = s_axis_tdata[23:22];
            num_dma_word_d = AW'(s_axis_tdata[15:3]) + AW'(s_axis_tdata[2:0] != 3'd0);
            word_cnt_d     = '0;
            if (s_axis_tdata[15:0] == 16'd0) begin
              len_err_d = 1'b1;
              state_d   = s_axis_tlast ? S_IDLE : S_DRAIN;
            end else if (s_axis_tlast) begin
              len_err_d = 1'b1;
              state_d   = S_IDLE;
            end else begin
              state_d = S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (accept) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = word_cnt_q;
            wr_data_d  = s_axis_tdata;
            word_cnt_d = word_cnt_inc;
            if (s_axis_tlast) begin
              if (word_cnt_inc == num_dma_word_q) begin
                state_d = S_WAIT_TX_DONE;
              end else begin
                len_err_d = 1'b1;
                state_d   = S_IDLE;
              end
            end else if (word_cnt_inc == num_dma_word_q) begin
              len_err_d = 1'b1;
              state_d   = S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (accept && s_axis_tlast) state_d = S_IDLE;
        end
        S_WAIT_TX_DONE: begin
          if (tx_done) begin
            tx_pkt_intr_d = 1'b1;
            state_d       = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // tready and tx_pkt_ready are registered views of the next state.
    tready_d = (state_d == S_HDR0) || (state_d == S_HDR1) ||
               (state_d == S_PAYLOAD) || (state_d == S_DRAIN);
    tx_pkt_ready_d = (state_d == S_WAIT_TX_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= S_IDLE;
      tready_q          <= 1'b0;
      timer_q           <= '0;
      word_cnt_q        <= '0;
      num_dma_word_q    <= '0;
      wr_en_q           <= 1'b0;
      wr_addr_q         <= '0;
      wr_data_q         <= '0;
      tsf_start_q       <= '0;
      pkt_len_q         <= '0;
      pkt_rate_q        <= '0;
      ht_flag_q         <= 1'b0;
      ht_sgi_q          <= 1'b0;
      queue_idx_q       <= '0;
      tx_pkt_ready_q    <= 1'b0;
      tx_pkt_intr_q     <= 1'b0;
      len_err_q         <= 1'b0;
      timeout_recover_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      tready_q          <= tready_d;
      timer_q           <= timer_d;
      word_cnt_q        <= word_cnt_d;
      num_dma_word_q    <= num_dma_word_d;
      wr_en_q           <= wr_en_d;
      wr_addr_q         <= wr_addr_d;
      wr_data_q         <= wr_data_d;
      tsf_start_q       <= tsf_start_d;
      pkt_len_q         <= pkt_len_d;
      pkt_rate_q        <= pkt_rate_d;
      ht_flag_q         <= ht_flag_d;
      ht_sgi_q          <= ht_sgi_d;
      queue_idx_q       <= queue_idx_d;
      tx_pkt_ready_q    <= tx_pkt_ready_d;
      tx_pkt_intr_q     <= tx_pkt_intr_d;
      len_err_q         <= len_err_d;
      timeout_recover_q <= timeout_recover_d;
    end
  end

  assign s_axis_tready   = tready_q;
  assign payload_wr_en   = wr_en_q;
  assign payload_wr_addr = wr_addr_q;
  assign payload_wr_data = wr_data_q;
  assign tsf_start       = tsf_start_q;
  assign pkt_len         = pkt_len_q;
  assign pkt_rate        = pkt_rate_q;
  assign ht_flag         = ht_flag_q;
  assign ht_sgi          = ht_sgi_q;
  assign queue_idx       = queue_idx_q;
  assign num_dma_word    = num_dma_word_q;
  assign tx_pkt_ready    = tx_pkt_ready_q;
  assign tx_pkt_intr     = tx_pkt_intr_q;
  assign len_err         = len_err_q;
  assign timeout_recover = timeout_recover_q;

endmodule

// File: tb/tb_tx_intf_s_axis_to_pl.sv
// Bench for tx_intf_s_axis_to_pl: table of packet shapes, randomized packets against a
// length-rule model, plus hand sequences for timeout and mid-packet reset.
module tb_tx_intf_s_axis_to_pl;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic        enable, timeout_enable, tsf_pulse_1M, tx_done;
  logic [12:0] timeout_top;
  logic        payload_wr_en;
  logic [13:0] payload_wr_addr, num_dma_word;
  logic [63:0] payload_wr_data, tsf_start;
  logic [15:0] pkt_len;
  logic [3:0]  pkt_rate;
  logic        ht_flag, ht_sgi;
  logic [1:0]  queue_idx;
  logic        tx_pkt_ready, tx_pkt_intr, len_err, timeout_recover;

  tx_intf_s_axis_to_pl dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .enable(enable), .timeout_enable(timeout_enable), .timeout_top(timeout_top),
    .tsf_pulse_1M(tsf_pulse_1M), .tx_done(tx_done),
    .payload_wr_en(payload_wr_en), .payload_wr_addr(payload_wr_addr),
    .payload_wr_data(payload_wr_data), .tsf_start(tsf_start), .pkt_len(pkt_len),
    .pkt_rate(pkt_rate), .ht_flag(ht_flag), .ht_sgi(ht_sgi), .queue_idx(queue_idx),
    .num_dma_word(num_dma_word), .tx_pkt_ready(tx_pkt_ready), .tx_pkt_intr(tx_pkt_intr),
    .len_err(len_err), .timeout_recover(timeout_recover)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pcnt = 0;

  // 1 MHz tick every 10 clocks.
  always @(posedge clk) begin
    cyc          <= cyc + 1;
    pcnt         <= (pcnt == 9) ? 0 : pcnt + 1;
    tsf_pulse_1M <= (pcnt == 9);
  end

  // Output monitor: cumulative logs sampled on the falling edge.
  logic [63:0] wr_data_log [0:4095];
  int          wr_addr_log [0:4095];
  int          wr_total = 0, len_err_total = 0, rdy_rise_total = 0, intr_total = 0, tmo_total = 0;
  logic        rdy_prev = 1'b0;
  always @(negedge clk) begin
    if (payload_wr_en && wr_total < 4096) begin
      wr_data_log[wr_total] <= payload_wr_data;
      wr_addr_log[wr_total] <= int'(payload_wr_addr);
      wr_total              <= wr_total + 1;
    end
    if (len_err)                    len_err_total  <= len_err_total + 1;
    if (tx_pkt_intr)                intr_total     <= intr_total + 1;
    if (timeout_recover)            tmo_total      <= tmo_total + 1;
    if (tx_pkt_ready && !rdy_prev)  rdy_rise_total <= rdy_rise_total + 1;
    rdy_prev <= tx_pkt_ready;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_ctl"}, {s_axis_tready, payload_wr_en, payload_wr_addr, tx_pkt_ready, tx_pkt_intr,
        len_err, timeout_recover, pkt_rate, ht_flag, ht_sgi, queue_idx, num_dma_word}, 64'd0);
    chk({nm, "_tsf"}, tsf_start, 64'd0);
    chk({nm, "_len"}, {48'd0, pkt_len}, 64'd0);
    chk({nm, "_wdata"}, payload_wr_data, 64'd0);
  endtask

  // Drive one word with a random idle gap first; wait for the handshake with a cycle budget.
  task automatic push_word(input logic [63:0] d, input bit last);
    int  waited;
    bit  accepted;
    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    waited   = 0;
    accepted = 0;
    while (!accepted && waited < 200) begin
      @(negedge clk);
      if (s_axis_tready) accepted = 1;
      @(posedge clk); #1;
      waited++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (!accepted) begin
      checks++;
      failures++;
      $display("FAIL push_word: tready never seen, got 0 expected 1 (cycle %0d)", cyc);
    end
  endtask

  logic [63:0] sent [0:255];
  logic [63:0] hdr0, hdr1;

  // Header + payload words; np<0 puts tlast on header word 0, np==0 on header word 1.
  task automatic send_pkt(input int len, input int np, input int rate, input bit sgi,
                          input int stall_at, input int stall_cyc);
    hdr0 = {$urandom, $urandom};
    hdr1 = {$urandom, $urandom};
    hdr1[15:0]  = len[15:0];
    hdr1[19:16] = rate[3:0];
    hdr1[21]    = sgi;
    if (np < 0) begin
      push_word(hdr0, 1'b1);
    end else begin
      push_word(hdr0, 1'b0);
      push_word(hdr1, np == 0);
      for (int i = 0; i < np; i++) begin
        sent[i % 256] = {$urandom, $urandom};
        push_word(sent[i % 256], i == np - 1);
        if (i == stall_at) repeat (stall_cyc) begin @(posedge clk); #1; end
      end
    end
  endtask

  // Reference rules: ceil(len/8) words expected; only an exact match with len!=0 is delivered.
  function automatic void model(input int len, input int np, output int wr, output bit good);
    int nw;
    nw   = (len + 7) / 8;
    wr   = (np < 0) ? 0 : ((np < nw) ? np : nw);
    good = (np >= 0) && (nw != 0) && (np == nw);
  endfunction

  task automatic run_pkt(input int len, input int np, input int rate, input bit sgi,
                         input int exp_wr, input bit exp_err, input bit exp_good,
                         input int stall_at, input int stall_cyc);
    int b_wr, b_err, b_rdy, b_intr, b_tmo, w, bad;
    b_wr = wr_total; b_err = len_err_total; b_rdy = rdy_rise_total;
    b_intr = intr_total; b_tmo = tmo_total;
    send_pkt(len, np, rate, sgi, stall_at, stall_cyc);
    if (exp_good) begin
      w = 0;
      while (!tx_pkt_ready && w < 30) begin @(posedge clk); #1; w++; end
      chk("tx_pkt_ready_set", tx_pkt_ready, 1);
      chk("num_dma_word", num_dma_word, (len + 7) / 8);
      chk("pkt_len", pkt_len, len);
      chk("fields", {pkt_rate, ht_flag, ht_sgi, queue_idx}, {hdr1[19:16], hdr1[20], hdr1[21], hdr1[23:22]});
      chk("tsf_start", tsf_start, hdr0);
      repeat ($urandom_range(0, 5)) begin @(posedge clk); #1; end
      chk("tx_pkt_ready_hold", tx_pkt_ready, 1);
      tx_done = 1'b1;
      @(posedge clk); #1;
      tx_done = 1'b0;
      chk("tx_pkt_intr_next_cycle", {tx_pkt_intr, tx_pkt_ready}, 2'b10);
      @(posedge clk); #1;
      chk("tx_pkt_intr_one_cycle", tx_pkt_intr, 0);
    end else begin
      repeat (4) begin @(posedge clk); #1; end
      tx_done = 1'b1;
      @(posedge clk); #1;
      tx_done = 1'b0;
    end
    repeat (3) begin @(posedge clk); #1; end
    chk("wr_count", wr_total - b_wr, exp_wr);
    bad = 0;
    for (int i = 0; i < wr_total - b_wr; i++)
      if (wr_addr_log[b_wr + i] != i || wr_data_log[b_wr + i] !== sent[i % 256]) bad++;
    chk("wr_order_data", bad, 0);
    chk("len_err_count", len_err_total - b_err, exp_err);
    chk("ready_rise_count", rdy_rise_total - b_rdy, exp_good);
    chk("intr_count", intr_total - b_intr, exp_good);
    chk("timeout_count", tmo_total - b_tmo, 0);
  endtask

  typedef struct {
    int len; int np; int rate; bit sgi;
    int exp_wr; bit exp_err; bit exp_good;
  } vec_t;
  vec_t tbl [10];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int wr_m, elapsed, b_wr, b_tmo, c0;
    bit good_m, seen, rdy_at;
    tbl[0] = '{20,   3,   4, 1, 3,   0, 1};
    tbl[1] = '{16,   1,   2, 0, 1,   1, 0};
    tbl[2] = '{8,    3,   5, 0, 1,   1, 0};
    tbl[3] = '{0,    2,   1, 0, 0,   1, 0};
    tbl[4] = '{0,    0,   1, 0, 0,   1, 0};
    tbl[5] = '{24,   0,   3, 1, 0,   1, 0};
    tbl[6] = '{40,   -1,  0, 0, 0,   1, 0};
    tbl[7] = '{64,   8,   7, 1, 8,   0, 1};
    tbl[8] = '{9,    2,   8, 0, 2,   0, 1};
    tbl[9] = '{1500, 188, 6, 1, 188, 0, 1};

    rst = 1'b1; s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    enable = 1'b1; timeout_enable = 1'b1; timeout_top = 13'd5; tx_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i])
      run_pkt(tbl[i].len, tbl[i].np, tbl[i].rate, tbl[i].sgi,
              tbl[i].exp_wr, tbl[i].exp_err, tbl[i].exp_good, -1, 0);

    for (int k = 0; k < 10; k++) begin
      int len, nw, np, mode;
      len  = $urandom_range(1, 400);
      nw   = (len + 7) / 8;
      mode = $urandom_range(0, 3);
      np   = (mode < 2) ? nw : ((mode == 2) ? nw - 1 : nw + $urandom_range(1, 2));
      model(len, np, wr_m, good_m);
      run_pkt(len, np, $urandom_range(0, 15), 1'($urandom), wr_m, !good_m, good_m, -1, 0);
    end

    // Timeout: stall after the first payload word of a 3-word packet.
    b_wr = wr_total; b_tmo = tmo_total;
    push_word({$urandom, $urandom}, 1'b0);
    push_word(64'd24, 1'b0);
    push_word(64'h1234, 1'b0);
    c0 = cyc; seen = 0; elapsed = 0; rdy_at = 1'b1;
    for (int i = 0; i < 120 && !seen; i++) begin
      @(negedge clk);
      if (timeout_recover) begin
        seen = 1; elapsed = cyc - c0; rdy_at = s_axis_tready;
      end
    end
    chk("timeout_pulse_seen", seen, 1);
    chk("timeout_delay_in_window", (elapsed >= 48 && elapsed <= 66), 1);
    chk("timeout_tready_low", rdy_at, 0);
    @(posedge clk); #1;
    repeat (3) begin @(posedge clk); #1; end
    chk("timeout_pulse_count", tmo_total - b_tmo, 1);
    chk("timeout_wr_count", wr_total - b_wr, 1);
    run_pkt(20, 3, 4, 1, 3, 0, 1, -1, 0);

    // Timeout disabled: the same stall waits indefinitely and then completes.
    timeout_enable = 1'b0;
    run_pkt(24, 3, 2, 0, 3, 0, 1, 0, 100);
    timeout_enable = 1'b1;

    // Reset asserted in PAYLOAD, then a fresh packet.
    push_word({$urandom, $urandom}, 1'b0);
    push_word(64'd80, 1'b0);
    for (int i = 0; i < 4; i++) push_word({$urandom, $urandom}, 1'b0);
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_reset");
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk); #1;
    run_pkt(20, 3, 4, 1, 3, 0, 1, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
